// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO and built-in baud generator.
// Word length, parity, stop bits and divisor are sampled from the pins at the moment a word is popped.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DIV_WIDTH-1:0]          clk_div,
    input  logic [4:0]                    bits_per_word,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_en,
    input  logic                          ovf_clr,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int NW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] div;
        logic [NW-1:0]        n;
        logic [1:0]           pmode;
        logic                 two;
        logic                 par;
    } cfg_t;

    // ---------------- FIFO ----------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         count, count_n;
    logic                  full_r, empty_r, ovf_r;
    logic                  pop, push;
    logic [DATA_WIDTH-1:0] head;

    state_t state, state_n;

    assign head = mem[rd_ptr];
    assign pop  = (state == IDLE) && en && (count != '0);
    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign push = wr_en && ((count != LW'(FIFO_DEPTH)) || pop);
    assign count_n = count + LW'(push) - LW'(pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            ovf_r   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count   <= count_n;
            full_r  <= (count_n == LW'(FIFO_DEPTH));
            empty_r <= (count_n == '0);
            if (wr_en && !push)
                ovf_r <= 1'b1;
            else if (ovf_clr)
                ovf_r <= 1'b0;
        end
    end

    assign full     = full_r;
    assign empty    = empty_r;
    assign level    = count;
    assign overflow = ovf_r;

    // ---------------- configuration capture ----------------
    logic [NW-1:0]         n_sel;
    logic [DATA_WIDTH-1:0] masked;
    logic                  par_sel;

    always_comb begin
        if (bits_per_word == 5'd0 || int'(bits_per_word) > DATA_WIDTH)
            n_sel = NW'(DATA_WIDTH);
        else
            n_sel = NW'(bits_per_word);
        masked = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            masked[i] = head[i] & (i < int'(n_sel));
        case (parity_mode)
            2'b01:   par_sel = ~(^masked);
            2'b10:   par_sel = ^masked;
            2'b11:   par_sel = 1'b1;
            default: par_sel = 1'b0;
        endcase
    end

    // ---------------- transmit FSM ----------------
    logic [DIV_WIDTH-1:0]  baud_cnt, baud_n;
    logic [NW-1:0]         bit_cnt, bit_n;
    logic [DATA_WIDTH-1:0] shreg, sh_n;
    cfg_t                  cfg, cfg_n;
    logic                  bit_end, done, tx_c;

    assign bit_end = (baud_cnt == cfg.div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            cfg      <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= sh_n;
            cfg      <= cfg_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = bit_end ? '0 : baud_cnt + DIV_WIDTH'(1);
        bit_n   = bit_cnt;
        sh_n    = shreg;
        cfg_n   = cfg;
        done    = 1'b0;
        tx_c    = 1'b1;
        case (state)
            IDLE: begin
                baud_n = '0;
                bit_n  = '0;
                if (pop) begin
                    state_n = START;
                    sh_n    = head;
                    cfg_n   = '{div: clk_div, n: n_sel, pmode: parity_mode,
                                two: two_stop, par: par_sel};
                end
            end
            START: begin
                tx_c = 1'b0;
                if (bit_end)
                    state_n = DATA;
            end
            DATA: begin
                tx_c = shreg[0];
                if (bit_end) begin
                    sh_n = shreg >> 1;
                    if (bit_cnt == cfg.n - NW'(1)) begin
                        bit_n   = '0;
                        state_n = (cfg.pmode != 2'b00) ? PARITY : STOP;
                    end else begin
                        bit_n = bit_cnt + NW'(1);
                    end
                end
            end
            PARITY: begin
                tx_c = cfg.par;
                if (bit_end)
                    state_n = STOP;
            end
            STOP: begin
                // bit_cnt tracks which stop bit is on the line
                if (bit_end) begin
                    if (cfg.two && bit_cnt == '0) begin
                        bit_n = NW'(1);
                    end else begin
                        state_n = IDLE;
                        done    = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign tx_done = done;
    assign tx      = tx_c;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frame table, FIFO/overflow sequences, reset mid-frame,
// and randomized frames checked against a bit-list model of the line.
module tb_uart_tx_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int DVW   = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic [DVW-1:0] clk_div = '0;
    logic [4:0]     bits_per_word = 5'd8;
    logic [1:0]     parity_mode = 2'b00;
    logic           two_stop = 1'b0;
    logic [DW-1:0]  wr_data = '0;
    logic           wr_en = 1'b0;
    logic           ovf_clr = 1'b0;
    logic           full, empty, overflow, busy, tx_done, tx;
    logic [LW-1:0]  level;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_div, cur_bpw, cur_pm, cur_two;

    uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DVW)) dut (
        .clk(clk), .rst(rst), .en(en), .clk_div(clk_div), .bits_per_word(bits_per_word),
        .parity_mode(parity_mode), .two_stop(two_stop), .wr_data(wr_data), .wr_en(wr_en),
        .ovf_clr(ovf_clr), .full(full), .empty(empty), .level(level), .overflow(overflow),
        .busy(busy), .tx_done(tx_done), .tx(tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input int div, input int bpw, input int pm, input int two);
        cur_div = div; cur_bpw = bpw; cur_pm = pm; cur_two = two;
        clk_div = DVW'(div);
        bits_per_word = 5'(bpw);
        parity_mode = 2'(pm);
        two_stop = 1'(two);
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        wr_data = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    function automatic int model_n(input int bpw);
        return (bpw == 0 || bpw > DW) ? DW : bpw;
    endfunction

    // -1 means no parity bit on the line
    function automatic int model_par(input logic [DW-1:0] d, input int n, input int pm);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(d[i]);
        case (pm)
            0:       return -1;
            1:       return (ones % 2 == 0) ? 1 : 0;
            2:       return ones % 2;
            default: return 1;
        endcase
    endfunction

    // Waits for a frame start, then checks tx/tx_done/busy every cycle of it.
    // flags bit0: scramble config pins mid-frame; bit1: drop en mid-frame.
    task automatic expect_frame(input logic [DW-1:0] d, input int n, input int par,
                                input int nstop, input int div, input int flags,
                                output int gap, output int flen);
        bit q[$];
        int len;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) q.push_back(d[i]);
        if (par >= 0) q.push_back(par[0]);
        for (int i = 0; i < nstop; i++) q.push_back(1'b1);
        len = q.size() * (div + 1);
        gap = 0;
        flen = 0;
        while (!(busy === 1'b1 && tx === 1'b0) && gap < 300) begin
            @(negedge clk);
            gap++;
        end
        if (gap >= 300) begin
            chk("frame_start_timeout", 32'(gap), 32'd0);
            return;
        end
        for (int c = 0; c < len; c++) begin
            chk("tx_bit", {31'd0, tx}, {31'd0, q[c / (div + 1)]});
            chk("tx_done_pos", {31'd0, tx_done}, {31'd0, c == len - 1});
            chk("busy_in_frame", {31'd0, busy}, 32'd1);
            if (tx_done === 1'b1 && flen == 0) flen = c + 1;
            if (c == 2 && flags[0]) begin
                clk_div = DVW'($urandom_range(0, 7));
                bits_per_word = 5'($urandom_range(1, 31));
                parity_mode = 2'($urandom_range(0, 3));
                two_stop = 1'($urandom_range(0, 1));
            end
            if (c == 2 && flags[1]) en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic model_frame(input logic [DW-1:0] d, input int flags,
                               output int gap, output int flen);
        int n;
        n = model_n(cur_bpw);
        expect_frame(d, n, model_par(d, n, cur_pm), cur_two ? 2 : 1, cur_div, flags, gap, flen);
    endtask

    typedef struct {
        logic [DW-1:0] d;
        int bpw, pm, two, div, scr;
        int exp_n, exp_par, exp_stops, exp_len;
    } vec_t;

    vec_t vecs[8];
    logic [DW-1:0] mq[$];

    initial begin
        int gap, flen, k, n, p, nfr;
        logic [DW-1:0] d;
        set_cfg(0, 8, 0, 0);

        vecs[0] = '{16'h00A5, 8,  0, 0, 3, 0,  8, -1, 1, 40};
        vecs[1] = '{16'h0003, 7,  2, 1, 1, 0,  7,  0, 2, 22};
        vecs[2] = '{16'h0003, 7,  1, 1, 1, 0,  7,  1, 2, 22};
        vecs[3] = '{16'hFFFF, 0,  3, 0, 0, 0, 16,  1, 1, 19};
        vecs[4] = '{16'h1234, 20, 2, 0, 2, 1, 16,  1, 1, 57};
        vecs[5] = '{16'h00FF, 4,  1, 1, 0, 0,  4,  1, 2, 8};
        vecs[6] = '{16'h0100, 8,  2, 0, 0, 0,  8,  0, 1, 11};
        vecs[7] = '{16'hC3C3, 0,  0, 1, 1, 1, 16, -1, 2, 38};

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed frame table
        en = 1'b1;
        foreach (vecs[i]) begin
            set_cfg(vecs[i].div, vecs[i].bpw, vecs[i].pm, vecs[i].two);
            write_word(vecs[i].d);
            chk("wr_empty_drop", {31'd0, empty}, 32'd0);
            chk("wr_not_busy", {31'd0, busy}, 32'd0);
            expect_frame(vecs[i].d, vecs[i].exp_n, vecs[i].exp_par, vecs[i].exp_stops,
                         vecs[i].div, vecs[i].scr, gap, flen);
            chk("start_latency", 32'(gap), 32'd1);
            chk("frame_len", 32'(flen), 32'(vecs[i].exp_len));
        end

        // fill with en low, overflow, set-wins, clear, write+pop while full
        en = 1'b0;
        set_cfg(0, 8, 0, 0);
        repeat (3) @(negedge clk);
        mq.delete();
        for (int i = 0; i < DEPTH; i++) begin
            d = DW'(i * 37 + 5);
            write_word(d);
            mq.push_back(d);
        end
        chk("fill_level", 32'(level), 32'(DEPTH));
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_no_ovf", {31'd0, overflow}, 32'd0);
        write_word(16'h00EE);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_level", 32'(level), 32'(DEPTH));
        wr_data = 16'h0077; wr_en = 1'b1; ovf_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clear", {31'd0, overflow}, 32'd0);
        en = 1'b1; wr_data = 16'hBEEF; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        mq.push_back(16'hBEEF);
        chk("wrpop_level", 32'(level), 32'(DEPTH));
        chk("wrpop_full", {31'd0, full}, 32'd1);
        chk("wrpop_ovf", {31'd0, overflow}, 32'd0);
        nfr = mq.size();
        for (int i = 0; i < nfr; i++) begin
            model_frame(mq.pop_front(), 0, gap, flen);
            chk("drain_gap", 32'(gap), (i == 0) ? 32'd0 : 32'd1);
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // en dropped mid-frame: that frame completes, the next waits
        set_cfg(1, 8, 0, 0);
        write_word(16'h005C);
        write_word(16'h00C5);
        model_frame(16'h005C, 2, gap, flen);
        for (int c = 0; c < 20; c++) begin
            chk("en_low_idle_tx", {31'd0, tx}, 32'd1);
            chk("en_low_idle_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        chk("en_low_level", 32'(level), 32'd1);
        en = 1'b1;
        model_frame(16'h00C5, 0, gap, flen);
        chk("en_resume_gap", 32'(gap), 32'd1);

        // randomized single frames, half with config scrambled mid-frame
        for (int it = 0; it < 20; it++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 20), $urandom_range(0, 3),
                    $urandom_range(0, 1));
            d = DW'($urandom);
            write_word(d);
            n = model_n(cur_bpw);
            p = (cur_pm != 0) ? 1 : 0;
            model_frame(d, it % 2, gap, flen);
            chk("rnd_gap", 32'(gap), 32'd1);
            chk("rnd_len", 32'(flen), 32'((1 + n + p + (cur_two ? 2 : 1)) * (cur_div + 1)));
        end

        // randomized bursts against a queue model of the FIFO
        for (int b = 0; b < 3; b++) begin
            en = 1'b0;
            ovf_clr = 1'b1;
            @(negedge clk);
            ovf_clr = 1'b0;
            set_cfg($urandom_range(0, 2), $urandom_range(5, 16), $urandom_range(0, 3),
                    $urandom_range(0, 1));
            k = $urandom_range(1, DEPTH + 3);
            mq.delete();
            for (int i = 0; i < k; i++) begin
                d = DW'($urandom);
                write_word(d);
                if (mq.size() < DEPTH) mq.push_back(d);
            end
            chk("burst_level", 32'(level), 32'(mq.size()));
            chk("burst_full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
            chk("burst_ovf", {31'd0, overflow}, {31'd0, k > DEPTH});
            en = 1'b1;
            nfr = mq.size();
            for (int i = 0; i < nfr; i++) begin
                model_frame(mq.pop_front(), 0, gap, flen);
                chk("burst_gap", 32'(gap), 32'd1);
            end
            chk("burst_empty", {31'd0, empty}, 32'd1);
        end

        // reset in the middle of the data bits
        set_cfg(3, 8, 0, 0);
        en = 1'b1;
        write_word(16'h00A5);
        write_word(16'h0011);
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", {31'd0, tx}, 32'd1);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_empty", {31'd0, empty}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_level", 32'(level), 32'd0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            chk("post_rst_no_done", {31'd0, tx_done}, 32'd0);
            chk("post_rst_tx_idle", {31'd0, tx}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
